// File: rtl/matmul_sequencer.sv
// matmul_sequencer: drives the data-memory bus to compute C = A x B (NxN, unsigned).
// Ports: clk, rst_n, start, abort -> busy, done, mem_read/mem_write/mem_addr/mem_wdata; mem_rdata in.
// Optional `MATSEQ_OVF_EN adds a sticky ovf output for product/accumulate wrap.
module matmul_sequencer #(
  parameter int unsigned N      = 3,
  parameter logic [31:0] A_BASE = 32'h0000_0200,
  parameter logic [31:0] B_BASE = 32'h0000_0300,
  parameter logic [31:0] C_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
`ifdef MATSEQ_OVF_EN
  output logic        ovf,
`endif
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t      state_q, state_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  j_q, j_d;
  logic [3:0]  k_q, k_d;
  logic [31:0] a_q, a_d;
  logic [31:0] acc_q, acc_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] prod;
  logic [31:0] sum;

`ifdef MATSEQ_OVF_EN
  logic [63:0] prod_w;
  logic [32:0] sum_w;
  logic        ovf_q, ovf_d;

  assign prod_w = 64'(a_q) * 64'(mem_rdata);
  assign prod   = prod_w[31:0];
  assign sum_w  = {1'b0, acc_q} + {1'b0, prod};
  assign sum    = sum_w[31:0];
  assign ovf    = ovf_q;
`else
  assign prod = a_q * mem_rdata;
  assign sum  = acc_q + prod;
`endif

  function automatic logic [31:0] elem(
    input logic [31:0] base,
    input logic [3:0]  row,
    input logic [3:0]  col
  );
    logic [31:0] idx;
    idx = 32'(row) * 32'(N) + 32'(col);
    return base + (idx << 2);
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    acc_d   = acc_q;
`ifdef MATSEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_A;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
`ifdef MATSEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_RD_A: begin
        a_d     = mem_rdata;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        acc_d = sum;
`ifdef MATSEQ_OVF_EN
        if (prod_w[63:32] != 32'h0 || sum_w[32])
          ovf_d = 1'b1;
`endif
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = S_WR;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = S_RD_A;
        end
      end
      S_WR: begin
        acc_d = '0;
        if (j_q < LAST) begin
          j_d     = j_q + 4'd1;
          state_d = S_RD_A;
        end else if (i_q < LAST) begin
          j_d     = '0;
          i_d     = i_q + 4'd1;
          state_d = S_RD_A;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides every transition, DONE->IDLE included
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      a_d     = '0;
      acc_d   = '0;
    end
  end

  // outputs are decoded from the next state so they leave a flop
  always_comb begin
    busy_d  = state_d != S_IDLE;
    done_d  = state_d == S_DONE;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      S_RD_A: begin
        rd_d   = 1'b1;
        addr_d = elem(A_BASE, i_d, k_d);
      end
      S_RD_B: begin
        rd_d   = 1'b1;
        addr_d = elem(B_BASE, k_d, j_d);
      end
      S_WR: begin
        wr_d    = 1'b1;
        addr_d  = elem(C_BASE, i_d, j_d);
        wdata_d = acc_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MATSEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MATSEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed bench with a word memory and a per-cycle bus model.
// Covers identity, A*B, access order, abort, async reset, held start, optional ovf.
module tb_matmul_sequencer;

  localparam int N = 3;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MATSEQ_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  matmul_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef MATSEQ_OVF_EN
    .ovf       (ovf),
`endif
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem [0:255];
  logic [31:0] am [0:N*N-1];
  logic [31:0] bm [0:N*N-1];
  logic        load = 1'b0;
  logic [31:0] c_ab [0:8] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

  // C window is filled with a sentinel on every load
  always @(posedge clk) begin
    if (load) begin
      for (int x = 0; x < 256; x++) mem[x] <= 32'hDEAD_BEEF;
      for (int e = 0; e < N*N; e++) begin
        mem[128+e] <= am[e];
        mem[192+e] <= bm[e];
      end
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  rec_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   nrd = 0;
  int   nwr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic d, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] wd);
    rec_t x;
    x.busy = b; x.done = d; x.rd = r; x.wr = w; x.addr = a; x.wdata = wd;
    q.push_back(x);
  endtask

  // expected bus activity, one record per cycle after the start edge
  task automatic plan(input int n_acc, input bit full);
    int cnt;
    logic [31:0] s;
    cnt = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 32'h0;
        for (int k = 0; k < N; k++) begin
          if (cnt < n_acc) push(1, 0, 1, 0, 32'h200 + 32'(4*(r*N+k)), 0);
          cnt++;
          if (cnt < n_acc) push(1, 0, 1, 0, 32'h300 + 32'(4*(k*N+c)), 0);
          cnt++;
          s = s + am[r*N+k] * bm[k*N+c];
        end
        if (cnt < n_acc) push(1, 0, 0, 1, 32'h100 + 32'(4*(r*N+c)), s);
        cnt++;
      end
    end
    if (full) begin
      push(1, 1, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0, 0);
    end else begin
      repeat (3) push(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic cmp();
    rec_t x;
    if (rst_n !== 1'b1 || q.size() == 0) return;
    x = q.pop_front();
    nchk++;
    if (mem_read) nrd++;
    if (mem_write) nwr++;
    if (busy !== x.busy || done !== x.done || mem_read !== x.rd ||
        mem_write !== x.wr || mem_addr !== x.addr ||
        (x.wr && mem_wdata !== x.wdata)) begin
      nerr++;
      $display("FAIL cycle: got b=%b d=%b r=%b w=%b a=%h wd=%h expected b=%b d=%b r=%b w=%b a=%h wd=%h",
               busy, done, mem_read, mem_write, mem_addr, mem_wdata,
               x.busy, x.done, x.rd, x.wr, x.addr, x.wdata);
    end
  endtask

  task automatic load_mats();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic kick(input int n_acc, input bit full);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    plan(n_acc, full);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      nchk++;
      nerr++;
      $display("FAIL drain: got %0d pending records expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic set_id_b();
    for (int e = 0; e < N*N; e++) bm[e] = (e / N == e % N) ? 32'd1 : 32'd0;
  endtask

  task automatic set_seq(output logic [31:0] m [0:N*N-1]);
    for (int e = 0; e < N*N; e++) m[e] = 32'(e + 1);
  endtask

  task automatic chk_c_ab(input string nm);
    for (int e = 0; e < N*N; e++)
      chk($sformatf("%s_c%0d", nm, e), mem[64+e], c_ab[e]);
  endtask

  task automatic chk_c_id(input string nm);
    for (int e = 0; e < N*N; e++)
      chk($sformatf("%s_c%0d", nm, e), mem[64+e], 32'(e + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, w0;
    fork
      forever begin
        @(negedge clk);
        cmp();
      end
    join_none

    #12;
    chk("rst_ctl", {28'h0, busy, done, mem_read, mem_write}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    set_seq(am);
    set_id_b();
    load_mats();
    kick(63, 1'b1);
    drain();
    chk_c_id("ident");

    set_seq(bm);
    load_mats();
    r0 = nrd;
    w0 = nwr;
    kick(63, 1'b1);
    chk("seq0", q[0].addr, 32'h200);
    chk("seq1", q[1].addr, 32'h300);
    chk("seq2", q[2].addr, 32'h204);
    chk("seq3", q[3].addr, 32'h30C);
    chk("seq4", q[4].addr, 32'h208);
    chk("seq5", q[5].addr, 32'h318);
    chk("seq6", q[6].addr, 32'h100);
    chk("seq6_wd", q[6].wdata, 32'd30);
    drain();
    chk("reads", 32'(nrd - r0), 32'd54);
    chk("writes", 32'(nwr - w0), 32'd9);
    chk_c_ab("axb");

    load_mats();
    kick(20, 1'b0);
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    drain();
    chk("abort_c00", mem[64], 32'd30);
    chk("abort_c01", mem[65], 32'd36);
    chk("abort_c02", mem[66], 32'hDEAD_BEEF);
    chk("abort_c10", mem[67], 32'hDEAD_BEEF);
    kick(63, 1'b1);
    drain();
    chk_c_ab("post_abort");

    set_id_b();
    load_mats();
    kick(63, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_ctl", {28'h0, busy, done, mem_read, mem_write}, 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_c00", mem[64], 32'hDEAD_BEEF);
    kick(63, 1'b1);
    drain();
    chk_c_id("post_rst");

    set_seq(bm);
    load_mats();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    plan(63, 1'b1);
    plan(63, 1'b1);
    repeat (70) @(posedge clk);
    #1 start = 1'b0;
    drain();
    chk_c_ab("held");

`ifdef MATSEQ_OVF_EN
    set_id_b();
    for (int e = 0; e < N*N; e++) am[e] = bm[e];
    am[0] = 32'h0001_0000;
    bm[0] = 32'h0001_0000;
    load_mats();
    kick(63, 1'b1);
    drain();
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    chk("ovf_c00", mem[64], 32'h0);
    set_seq(am);
    set_id_b();
    load_mats();
    kick(63, 1'b1);
    chk("ovf_clr", {31'h0, ovf}, 32'h0);
    drain();
    chk("ovf_stay", {31'h0, ovf}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
